mix_columns: RTL and testbench
==============================

# mix_columns

AES MixColumns round stage. Each clock it transforms a 128-bit AES state by multiplying every 4-byte column by the fixed MixColumns matrix over GF(2^8), and registers the result. It sits in the encryption round datapath between ShiftRows and AddRoundKey, and is bypassed by the round controller in the final round.

## Interface
- Parameters: none.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- state_in  input  128  AES state entering the stage.
- state_out  output  128  registered MixColumns result.

## Operation
- State layout is column-major.
  - Column c (c = 0..3) occupies state[127-32c -: 32].
  - Within a column, row 0 is the most significant byte: row r = bits [127-32c-8r -: 8].
  - Displayed as a 4x4 matrix, row r is bytes [127-8r], [95-8r], [63-8r], [31-8r].
- The four columns are processed independently and in parallel with identical logic.
- For a column with bytes a0..a3 (row 0..3), output bytes b0..b3 are:
  - b0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - b1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - b2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - b3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
- GF(2^8) arithmetic uses the AES polynomial x^8+x^4+x^3+x+1.
  - 2·x = xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - 3·x = xtime(x) ^ x.
  - All additions are XOR; there is no carry and no width growth, so every byte stays 8 bits.
- The computation is purely combinational from state_in to the register input. There is no state machine, handshake or valid signal; the block transforms every cycle.

## Timing
- state_out is registered on the rising edge of clk.
- Latency is exactly 1 cycle: state_out after edge k equals MixColumns(state_in sampled at edge k).
- Throughput is one state per cycle. Back-to-back inputs each appear one cycle later, in order.
- Reset:
  - If rst=1 at a rising edge, state_out becomes 128'h0 and state_in is ignored for that edge.
  - Reset asserted mid-stream discards the in-flight value.
  - The first edge with rst=0 loads MixColumns(state_in).
- Before the first reset, state_out is undefined. The bench must apply reset first.
- state_out is stable for the full cycle between edges. Changes on state_in between edges do not affect it.

## Test plan
- Reset: hold rst=1 for 2 edges with state_in=128'hd4bf5d30e0b452aeb84111f11e2798e5 -> state_out=128'h0. Release rst -> one edge later state_out=128'h046681e5e0cb199a48f8d37a2806264c (FIPS-197 round 1 vector).
- Single-column vectors, repeated into all four columns, each result after 1 edge:
  - db135345 -> 8e4da1bc
  - f20a225c -> 9fdc589d
  - 2d26314c -> 4d7ebdf8
  - d4d4d4d5 -> d5d5d7d6
- Fixed points:
  - 128'h0 -> 128'h0.
  - All columns 01010101 -> unchanged.
  - All columns c6c6c6c6 -> unchanged.
- Pipelining: apply a different vector each cycle for 5 consecutive cycles. Each output appears exactly one edge after its input, with no bubbles.
- Reset mid-stream: assert rst for 1 edge between two valid inputs -> that edge outputs 0 and the next edge outputs the correct transform.
- Random regression: 1000 random states compared against a software reference model of MixColumns. Also apply InvMixColumns to state_out and require the original input to be recovered.

Source files
------------

// File: rtl/mix_columns.sv
// mix_columns: AES MixColumns round stage.
//
// Multiplies each 4-byte column of a 128-bit AES state by the fixed MixColumns
// matrix over GF(2^8), using the polynomial x^8+x^4+x^3+x+1. The result is registered,
// so latency is one cycle and throughput is one state per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; clears state_out to zero
//   state_in   128-bit state entering the stage (column-major, row 0 = MSB of column)
//   state_out  registered MixColumns result
module mix_columns (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);

  // Multiply by x in GF(2^8): shift left, reduce by 0x1b when the top bit falls out.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
  // 3*a is expressed as xtime(a) ^ a, so each byte needs only one xtime.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    x0 = xtime(a0);
    x1 = xtime(a1);
    x2 = xtime(a2);
    x3 = xtime(a3);
    b0 = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    b3 = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
    return {b0, b1, b2, b3};
  endfunction

  logic [127:0] state_d;
  logic [127:0] state_q;

  // Columns are independent; column c sits at bits [127-32c -: 32].
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign state_d[127-32*c -: 32] = mix_col(state_in[127-32*c -: 32]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: directed vectors with known results,
// pipelining, mid-stream reset, and a random sweep against a reference model
// plus an InvMixColumns round-trip.
module tb_mix_columns;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state_in;
  logic [127:0] state_out;

  int n_checks = 0;
  int n_pass   = 0;

  mix_columns dut (
    .clk       (clk),
    .rst       (rst),
    .state_in  (state_in),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %032h expected %032h", tag, got, exp);
    end
  endtask

  // Generic GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Apply a circulant matrix with first row {m0,m1,m2,m3} to every column.
  function automatic logic [127:0] circ(input logic [127:0] s, input logic [7:0] m0,
                                        input logic [7:0] m1, input logic [7:0] m2,
                                        input logic [7:0] m3);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   m [4];
    logic [7:0]   b;
    m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(a[k], m[(k - row + 4) % 4]);
        r[127-32*c-8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mc_model(input logic [127:0] s);
    return circ(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] s);
    return circ(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  // Drive inputs, take one rising edge, land 1 time unit after it.
  task automatic step(input logic r, input logic [127:0] din);
    rst      = r;
    state_in = din;
    @(posedge clk);
    #1;
  endtask

  logic [31:0]  col_in  [4] = '{32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'hd4d4d4d5};
  logic [31:0]  col_out [4] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'hd5d5d7d6};
  logic [127:0] fixed   [3] = '{128'h0, {4{32'h01010101}}, {4{32'hc6c6c6c6}}};
  logic [127:0] pipe    [5];
  logic [127:0] rnd;

  localparam logic [127:0] FipsIn  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FipsOut = 128'h046681e5e0cb199a48f8d37a2806264c;

  initial begin
    rst      = 1'b1;
    state_in = FipsIn;
    @(negedge clk);

    // Reset held for two edges ignores state_in.
    step(1'b1, FipsIn);
    check("reset_edge1", state_out, 128'h0);
    step(1'b1, FipsIn);
    check("reset_edge2", state_out, 128'h0);
    step(1'b0, FipsIn);
    check("fips_round1", state_out, FipsOut);

    // Output stays put when state_in changes between edges.
    state_in = {4{32'hdb135345}};
    #3;
    check("hold_between_edges", state_out, FipsOut);

    for (int i = 0; i < 4; i++) begin
      step(1'b0, {4{col_in[i]}});
      check($sformatf("column_vec%0d", i), state_out, {4{col_out[i]}});
    end

    for (int i = 0; i < 3; i++) begin
      step(1'b0, fixed[i]);
      check($sformatf("fixed_point%0d", i), state_out, fixed[i]);
    end

    // Mixed columns in one state: each column transforms independently.
    step(1'b0, {col_in[0], col_in[1], col_in[2], col_in[3]});
    check("mixed_columns", state_out, {col_out[0], col_out[1], col_out[2], col_out[3]});

    // Back-to-back: each edge shows the transform of the input applied just before it.
    pipe[0] = FipsIn;
    pipe[1] = {4{col_in[0]}};
    pipe[2] = {col_in[3], col_in[2], col_in[1], col_in[0]};
    pipe[3] = {4{32'h01010101}};
    pipe[4] = {4{col_in[1]}};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, pipe[i]);
      check($sformatf("pipe%0d", i), state_out, mc_model(pipe[i]));
    end
    check("pipe_dir2", state_out, {4{col_out[1]}});

    // Reset between two valid inputs drops the one presented during reset.
    step(1'b0, {4{col_in[2]}});
    check("midrst_before", state_out, {4{col_out[2]}});
    step(1'b1, {4{col_in[3]}});
    check("midrst_zero", state_out, 128'h0);
    step(1'b0, FipsIn);
    check("midrst_after", state_out, FipsOut);

    for (int i = 0; i < 1000; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(1'b0, rnd);
      check($sformatf("rand%0d", i), state_out, mc_model(rnd));
      check($sformatf("inv_rand%0d", i), inv_model(state_out), rnd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
